// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit_pkg
//  Purpose  : Shared definitions for the execute-stage ALU: ALU op-codes
//             (common with the ALU control decoder), FSM state encoding,
//             default datapath width and an op-class helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_exec_unit_pkg;

    localparam int c_WIDTH = 32;

    // ALU control op-codes
    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd6;
    localparam logic [3:0] c_OP_SLT  = 4'd7;
    localparam logic [3:0] c_OP_SLTU = 4'd8;
    localparam logic [3:0] c_OP_SLL  = 4'd9;
    localparam logic [3:0] c_OP_SRL  = 4'd10;

    // FSM state encoding
    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == c_OP_SLL) || (op == c_OP_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_comb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_comb
//  Purpose  : Purely combinational single-cycle ALU operations
//             (AND, OR, ADD, SUB, SLT, SLTU) with signed-overflow flag.
//             Shift and undefined op-codes yield result 0, overflow 0.
//  Ports    : i_alu_ctl  - op-code
//             i_a, i_b   - operands
//             o_result   - operation result
//             o_overflow - signed overflow (ADD/SUB only)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic [3:0]       i_alu_ctl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt_s;
    logic             w_lt_u;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_lt_s = $signed(i_a) < $signed(i_b);
    assign w_lt_u = i_a < i_b;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_alu_ctl)
            c_OP_AND: o_result = i_a & i_b;
            c_OP_OR:  o_result = i_a | i_b;
            c_OP_ADD: begin
                o_result   = w_sum;
                // same-sign operands producing a result of the other sign
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            c_OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_s};
            c_OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_u};
            default: begin
                o_result   = '0;
                o_overflow = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Execute-stage arithmetic unit. Single-cycle ops go through
//             alu_comb; SLL/SRL use an iterative one-bit-per-cycle shifter
//             with a start/busy/done handshake.
//  Ports    : clk, reset (async, active-high)
//             start, alu_ctl, a, b, shamt - request and operands
//             busy     - shift in progress
//             done     - one-cycle pulse, outputs just updated
//             result, zero, overflow - registered outputs
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    logic [c_ST_W-1:0] r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [4:0]        r_count;
    logic              r_shl;       // 1: shift left, 0: logical right
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_ovf;

    logic [WIDTH-1:0]  w_comb_res;
    logic              w_comb_ovf;
    logic              w_is_shift;
    logic [WIDTH-1:0]  w_single_res;
    logic [WIDTH-1:0]  w_shift_next;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_alu_ctl  (alu_ctl),
        .i_a        (a),
        .i_b        (b),
        .o_result   (w_comb_res),
        .o_overflow (w_comb_ovf)
    );

    assign w_is_shift   = is_shift_op(alu_ctl);
    // a shift by zero completes in one cycle and simply passes b through
    assign w_single_res = w_is_shift ? b : w_comb_res;
    assign w_shift_next = r_shl ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_shreg  <= '0;
            r_count  <= '0;
            r_shl    <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        if (w_is_shift && (shamt != 5'd0)) begin
                            r_shreg <= b;
                            r_count <= shamt;
                            r_shl   <= (alu_ctl == c_OP_SLL);
                            r_state <= c_ST_SHIFT;
                        end else begin
                            r_result <= w_single_res;
                            r_zero   <= (w_single_res == '0);
                            r_ovf    <= w_comb_ovf;
                            r_state  <= c_ST_DONE;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_count <= r_count - 5'd1;
                    // last step: commit the value being shifted in this cycle
                    if (r_count == 5'd1) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_ovf    <= 1'b0;
                        r_state  <= c_ST_DONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == c_ST_SHIFT);
    assign done     = (r_state == c_ST_DONE);
    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_ovf;

endmodule
`default_nettype wire
